// File: rtl/fixed_dot_product_accumulator_pkg.sv
// Shared fixed-point helpers: result-width sizing and sign extension.
package fixed_dot_product_accumulator_pkg;

  // Widest value the sign-extension helper can carry.
  localparam int FXP_MAXW = 128;

  // Width that holds a sum of `depth` signed in_width terms plus an optional bias.
  function automatic int fxp_out_width(input int in_width, input int depth, input int has_bias);
    return in_width + $clog2(depth) + has_bias;
  endfunction

  // Replicate bit [from_width-1] of value into every higher bit.
  // The caller truncates the result to its own target width.
  function automatic logic [FXP_MAXW-1:0] sext(input logic [FXP_MAXW-1:0] value,
                                               input int from_width);
    logic [FXP_MAXW-1:0] r;
    r = value;
    for (int i = 0; i < FXP_MAXW; i++) begin
      if (i >= from_width) r[i] = value[from_width-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_dot_product_accumulator.sv
// Accumulates IN_DEPTH partial-sum beats into one dot-product result, adding an
// optional bias on the first beat. The output register is separate from the
// accumulator so the next result builds up while the previous one drains.
module fixed_dot_product_accumulator
  import fixed_dot_product_accumulator_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int IN_DEPTH   = 4,
  parameter int HAS_BIAS   = 1,
  parameter int BIAS_WIDTH = IN_WIDTH,
  parameter int OUT_WIDTH  = fxp_out_width(IN_WIDTH, IN_DEPTH, HAS_BIAS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic [BIAS_WIDTH-1:0] bias,
  input  logic                  bias_valid,
  output logic                  bias_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int              CNT_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_DEPTH - 1);
  localparam bit              USE_BIAS = (HAS_BIAS != 0);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  logic                 first, last, need_bias, can_last, in_fire;
  logic [OUT_WIDTH-1:0] data_ext, bias_ext, term, sum;

  assign first     = (cnt_q == '0);
  assign last      = (cnt_q == LAST_IDX);
  assign need_bias = first && USE_BIAS;

  // Operands sign-extended to the result width; wrap-around is intentional.
  assign data_ext = OUT_WIDTH'(sext(FXP_MAXW'(data_in), IN_WIDTH));
  assign bias_ext = OUT_WIDTH'(sext(FXP_MAXW'(bias), BIAS_WIDTH));
  assign term     = data_ext + (need_bias ? bias_ext : '0);
  assign sum      = (first ? '0 : acc_q) + term;

  // Only the last beat needs a free output slot; a first beat with bias
  // waits for the bias so both handshakes fire together.
  assign can_last      = !last || !out_valid_q || data_out_ready;
  assign data_in_ready = can_last && (!need_bias || bias_valid);
  assign bias_ready    = need_bias && data_in_valid && can_last;
  assign in_fire       = data_in_valid && data_in_ready;

  assign data_out       = out_q;
  assign data_out_valid = out_valid_q;

  // Next state: drain the output first, then let an accepted last beat reload it.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && data_out_ready) out_valid_d = 1'b0;
    if (in_fire) begin
      if (last) begin
        out_d       = sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial result and any pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fixed_dot_product_accumulator.sv
// Bench for fixed_dot_product_accumulator: four configurations, each tracked by a
// sum-of-beats model, plus a table of hand-computed result values per instance.
module tb_fixed_dot_product_accumulator;

  // Instances: 0 = depth4 bias, 1 = depth4 no bias, 2 = depth1 bias, 3 = depth4 OUT_WIDTH=8
  localparam int DEPS [4] = '{4, 4, 1, 4};
  localparam int HBS  [4] = '{1, 0, 1, 0};
  localparam int OWS  [4] = '{11, 10, 9, 8};
  localparam int LIT_N[4] = '{1, 4, 3, 1};
  localparam longint LIT [4][4] = '{'{2, 0, 0, 0}, '{10, 4, 8, 4}, '{6, 7, 8, 0}, '{-4, 0, 0, 0}};

  logic clk = 1'b0;
  logic rst;
  logic [3:0][7:0]  din, bias;
  logic [3:0]       dv, bv, ordy, irdy, brdy, ovld;
  logic [3:0][63:0] dout_x;

  int  checks = 0, failures = 0, tmo_cnt = 0;
  bit  done = 1'b0, fin = 1'b0;

  longint m_acc[4], m_out[4];
  int     m_cnt[4];
  bit     m_ov[4];
  int     lit_i[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int OW = OWS[g];
    logic [OW-1:0] dout;
    if (g == 3) begin : ov
      fixed_dot_product_accumulator #(.IN_WIDTH(8), .IN_DEPTH(DEPS[g]), .HAS_BIAS(HBS[g]),
                                      .OUT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .data_in(din[g]), .data_in_valid(dv[g]), .data_in_ready(irdy[g]),
        .bias(bias[g]), .bias_valid(bv[g]), .bias_ready(brdy[g]),
        .data_out(dout), .data_out_valid(ovld[g]), .data_out_ready(ordy[g]));
    end else begin : df
      fixed_dot_product_accumulator #(.IN_WIDTH(8), .IN_DEPTH(DEPS[g]), .HAS_BIAS(HBS[g])) u_dut (
        .clk(clk), .rst(rst), .data_in(din[g]), .data_in_valid(dv[g]), .data_in_ready(irdy[g]),
        .bias(bias[g]), .bias_valid(bv[g]), .bias_ready(brdy[g]),
        .data_out(dout), .data_out_valid(ovld[g]), .data_out_ready(ordy[g]));
    end
    assign dout_x[g] = 64'(dout);
  end

  task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, g, got, exp);
    end
  endtask

  // Compare process: checks every instance against its model on each falling
  // edge, then advances the model with the inputs that the next rising edge sees.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      logic [63:0] mk;
      bit first, last, nb, cl, eir, ebr;
      longint term, sum;
      mk = (64'd1 << OWS[g]) - 64'd1;
      if (rst) begin
        m_cnt[g] = 0; m_acc[g] = 0; m_out[g] = 0; m_ov[g] = 1'b0;
      end
      first = (m_cnt[g] == 0);
      last  = (m_cnt[g] == DEPS[g] - 1);
      nb    = first && (HBS[g] != 0);
      cl    = !last || !m_ov[g] || ordy[g];
      eir   = cl && (!nb || bv[g]);
      ebr   = nb && dv[g] && cl;
      chk("in_ready",  g, 64'(irdy[g]), 64'(eir));
      chk("bias_ready", g, 64'(brdy[g]), 64'(ebr));
      chk("out_valid", g, 64'(ovld[g]), 64'(m_ov[g]));
      chk("data_out",  g, dout_x[g] & mk, 64'(m_out[g]) & mk);
      if (!rst) begin
        if (m_ov[g] && ordy[g]) begin
          if (lit_i[g] < LIT_N[g]) begin
            chk("result_literal", g, dout_x[g] & mk, 64'(LIT[g][lit_i[g]]) & mk);
            chk("model_literal",  g, 64'(m_out[g]) & mk, 64'(LIT[g][lit_i[g]]) & mk);
          end else begin
            chk("extra_result", g, 64'(lit_i[g] + 1), 64'(LIT_N[g]));
          end
          lit_i[g]++;
        end
        term = longint'($signed(din[g])) + (nb ? longint'($signed(bias[g])) : 0);
        sum  = (first ? 0 : m_acc[g]) + term;
        if (m_ov[g] && ordy[g]) m_ov[g] = 1'b0;
        if (dv[g] && eir) begin
          if (last) begin
            m_out[g] = sum; m_ov[g] = 1'b1; m_acc[g] = 0; m_cnt[g] = 0;
          end else begin
            m_acc[g] = sum; m_cnt[g]++;
          end
        end
      end
    end
    if (done && !fin) begin
      for (int g = 0; g < 4; g++) chk("result_count", g, 64'(lit_i[g]), 64'(LIT_N[g]));
      chk("handshake_timeouts", 0, 64'(tmo_cnt), 64'd0);
      fin = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic put(input int g, input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    din[g] = v; dv[g] = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = irdy[g];
      @(posedge clk); #1;
    end
    if (!ok) tmo_cnt++;
    dv[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din = '0; bias = '0; dv = '0; bv = '0; ordy = '1;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // Depth 4, no bias: 1+2+3+4 = 10
    put(1, 8'd1); put(1, 8'd2); put(1, 8'd3); put(1, 8'd4);
    step(3);

    // Depth 4, bias -5 offered early: -1-2+3+7-5 = 2
    bias[0] = 8'hFB; bv[0] = 1'b1;
    step(3);
    put(0, 8'hFF);
    bv[0] = 1'b0;
    put(0, 8'hFE); put(0, 8'd3); put(0, 8'd7);
    step(3);

    // Backpressure: 4 held, 2,2,2 accepted, last 2 stalls, then 4 and 8 drain
    ordy[1] = 1'b0;
    for (int i = 0; i < 4; i++) put(1, 8'd1);
    for (int i = 0; i < 3; i++) put(1, 8'd2);
    din[1] = 8'd2; dv[1] = 1'b1;
    step(3);
    ordy[1] = 1'b1;
    put(1, 8'd2);
    step(3);

    // Depth 1 with bias 1 each beat: 6, 7, 8 on consecutive cycles
    bias[2] = 8'd1; bv[2] = 1'b1;
    put(2, 8'd5); put(2, 8'd6); put(2, 8'd7);
    bv[2] = 1'b0;
    step(3);

    // Wrap: 4 x 127 = 508 -> 0xFC in 8 bits
    for (int i = 0; i < 4; i++) put(3, 8'd127);
    step(3);

    // Reset mid-result with a full output register, then a clean 1,1,1,1
    ordy[1] = 1'b0;
    for (int i = 0; i < 4; i++) put(1, 8'd1);
    put(1, 8'd1); put(1, 8'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0; ordy[1] = 1'b1;
    for (int i = 0; i < 4; i++) put(1, 8'd1);
    step(3);

    done = 1'b1;
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
